// File: rtl/bus_move_sequencer_if.sv
// Command handshake and register-file strobe bundle for bus_move_sequencer.
// The tri-state data bus stays a plain inout port on the module.
interface bus_move_sequencer_if #(
    parameter int NREG = 4,
    parameter int W    = 16
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [1:0]      cmd_dst;
    logic [1:0]      cmd_src;
    logic [W-1:0]    cmd_imm;
    logic [NREG-1:0] reg_read;
    logic [NREG-1:0] reg_write;
    logic            busy;
    logic            done;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
        input  cmd_ready, reg_read, reg_write, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm,
        output cmd_ready, reg_read, reg_write, busy, done
    );
endinterface

// File: rtl/bus_move_sequencer.sv
// Register-transfer micro-sequencer: executes MOV/LDI/SWAP/CLR over the shared
// tri-state bus, one transfer per cycle, with every output registered.
module bus_move_sequencer #(
    parameter int NREG = 4,
    parameter int W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bus_move_sequencer_if.slave  seq,
    inout  wire  [W-1:0]         bus
);

    typedef enum logic [1:0] {IDLE, X1, X2, X3} state_t;
    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_LDI  = 2'b01,
        OP_SWAP = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    state_t          state;
    op_t             op_q;
    logic [1:0]      dst_q;
    logic [1:0]      src_q;
    logic [W-1:0]    temp;
    logic [NREG-1:0] rd_q;
    logic [NREG-1:0] wr_q;
    logic            drv_en_q;
    logic [W-1:0]    drv_val_q;
    logic            busy_q;
    logic            done_q;

    function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
        logic [NREG-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Strobes and bus drive for the next cycle are computed on the transition
    // into that state, so they depend only on registered state and latched fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_MOV;
            dst_q     <= '0;
            src_q     <= '0;
            temp      <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            drv_en_q  <= 1'b0;
            drv_val_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; these defaults are overridden later in
            // the same block and every read below sees the pre-edge values.
            rd_q      <= '0;
            wr_q      <= '0;
            drv_en_q  <= 1'b0;
            drv_val_q <= '0;
            done_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (seq.cmd_valid) begin
                        op_q   <= op_t'(seq.cmd_op);
                        dst_q  <= seq.cmd_dst;
                        src_q  <= seq.cmd_src;
                        state  <= X1;
                        busy_q <= 1'b1;
                        unique case (op_t'(seq.cmd_op))
                            OP_MOV: begin
                                rd_q <= onehot(seq.cmd_src);
                                wr_q <= onehot(seq.cmd_dst);
                            end
                            OP_LDI: begin
                                drv_en_q  <= 1'b1;
                                drv_val_q <= seq.cmd_imm;
                                wr_q      <= onehot(seq.cmd_dst);
                            end
                            OP_CLR: begin
                                drv_en_q <= 1'b1;
                                wr_q     <= onehot(seq.cmd_dst);
                            end
                            OP_SWAP: rd_q <= onehot(seq.cmd_src);
                        endcase
                    end
                end
                X1: begin
                    if (op_q == OP_SWAP) begin
                        temp  <= bus;
                        rd_q  <= onehot(dst_q);
                        wr_q  <= onehot(src_q);
                        state <= X2;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                X2: begin
                    drv_en_q  <= 1'b1;
                    drv_val_q <= temp;
                    wr_q      <= onehot(dst_q);
                    state     <= X3;
                end
                X3: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus           = drv_en_q ? drv_val_q : {W{1'bz}};
    assign seq.reg_read  = rd_q;
    assign seq.reg_write = wr_q;
    assign seq.busy      = busy_q;
    assign seq.cmd_ready = !busy_q;
    assign seq.done      = done_q;

endmodule

// File: tb/tb_bus_move_sequencer.sv
// Directed bench for bus_move_sequencer with a behavioural R0..R3 register file
// that drives the bus on reg_read and captures it on reg_write.
module tb_bus_move_sequencer;

    localparam logic [1:0] MOV = 2'b00, LDI = 2'b01, SWAP = 2'b10, CLR = 2'b11;

    logic clk = 1'b0;
    logic reset;
    wire  [15:0] bus;

    bus_move_sequencer_if #(.NREG(4), .W(16)) ifc ();

    bus_move_sequencer #(.NREG(4), .W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .seq   (ifc),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Register file model with a backdoor preload port.
    logic [15:0] rf [4];
    logic        pre_en = 1'b0;
    logic [1:0]  pre_idx = '0;
    logic [15:0] pre_val = '0;
    logic        probe_en = 1'b0;
    logic [1:0]  rd_sel;
    logic        tb_drv_en;
    logic [15:0] tb_drv_val;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < 4; i++)
            if (ifc.reg_read[i]) rd_sel = i[1:0];
    end

    // The probe stands in for an idle register so a stray sequencer drive shows up.
    assign tb_drv_en  = probe_en | (|ifc.reg_read);
    assign tb_drv_val = probe_en ? 16'h0000 : rf[rd_sel];
    assign bus        = tb_drv_en ? tb_drv_val : 16'hzzzz;

    always @(posedge clk) begin
        if (pre_en) rf[pre_idx] <= pre_val;
        else
            for (int i = 0; i < 4; i++)
                if (ifc.reg_write[i]) rf[i] <= bus;
    end

    // Per-cycle strobe invariants.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ($countones(ifc.reg_read) > 1 || $countones(ifc.reg_write) > 1 ||
                ifc.cmd_ready !== !ifc.busy) begin
                failures++;
                $display("FAIL invariant t=%0t read=%b write=%b ready=%b busy=%b (need onehot0, ready=!busy)",
                         $time, ifc.reg_read, ifc.reg_write, ifc.cmd_ready, ifc.busy);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic preload(input logic [1:0] idx, input logic [15:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    task automatic present(input logic [1:0] op, input logic [1:0] dst,
                           input logic [1:0] src, input logic [15:0] imm);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_dst   = dst;
        ifc.cmd_src   = src;
        ifc.cmd_imm   = imm;
    endtask

    // Returns at the negedge inside X1 (cycle N+1).
    task automatic send(input logic [1:0] op, input logic [1:0] dst,
                        input logic [1:0] src, input logic [15:0] imm);
        @(negedge clk);
        present(op, dst, src, imm);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = '0; ifc.cmd_dst = '0; ifc.cmd_src = '0; ifc.cmd_imm = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send(LDI, 2'd3, 2'd0, 16'hBEEF);
        chk("pre_reset_busy", {31'd0, ifc.busy}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        probe_en = 1'b1;
        #1;
        chk("reset_busy",   {31'd0, ifc.busy},      32'd0);
        chk("reset_ready",  {31'd0, ifc.cmd_ready}, 32'd1);
        chk("reset_done",   {31'd0, ifc.done},      32'd0);
        chk("reset_read",   {28'd0, ifc.reg_read},  32'd0);
        chk("reset_write",  {28'd0, ifc.reg_write}, 32'd0);
        chk("reset_bus",    {16'd0, bus},           32'h0000);
        probe_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle;
        probe_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_state", {11'd0, ifc.reg_read, ifc.reg_write, ifc.cmd_ready, bus},
                {11'd0, 4'b0000, 4'b0000, 1'b1, 16'h0000});
        end
        probe_en = 1'b0;
    endtask

    task automatic test_mov;
        preload(2'd2, 16'h5A5A);
        preload(2'd1, 16'h0000);
        send(MOV, 2'd1, 2'd2, 16'hFFFF);
        chk("mov_x1_read",  {28'd0, ifc.reg_read},  32'b0100);
        chk("mov_x1_write", {28'd0, ifc.reg_write}, 32'b0010);
        chk("mov_x1_bus",   {16'd0, bus},           32'h5A5A);
        chk("mov_x1_done",  {31'd0, ifc.done},      32'd0);
        @(negedge clk);
        chk("mov_done",     {31'd0, ifc.done},      32'd1);
        chk("mov_ready",    {31'd0, ifc.cmd_ready}, 32'd1);
        chk("mov_r1",       {16'd0, rf[1]},         32'h5A5A);
        chk("mov_r2",       {16'd0, rf[2]},         32'h5A5A);
        @(negedge clk);
        chk("mov_done_pulse", {31'd0, ifc.done},    32'd0);
        send(MOV, 2'd2, 2'd2, 16'h0000);
        @(negedge clk);
        chk("mov_same_done", {31'd0, ifc.done},     32'd1);
        chk("mov_same_r2",   {16'd0, rf[2]},        32'h5A5A);
    endtask

    task automatic test_ldi_clr;
        send(LDI, 2'd3, 2'd2, 16'hBEEF);
        chk("ldi_x1_read",  {28'd0, ifc.reg_read},  32'd0);
        chk("ldi_x1_write", {28'd0, ifc.reg_write}, 32'b1000);
        chk("ldi_x1_bus",   {16'd0, bus},           32'hBEEF);
        @(negedge clk);
        chk("ldi_r3",       {16'd0, rf[3]},         32'hBEEF);
        chk("ldi_done",     {31'd0, ifc.done},      32'd1);
        send(CLR, 2'd3, 2'd1, 16'hFFFF);
        chk("clr_x1_read",  {28'd0, ifc.reg_read},  32'd0);
        chk("clr_x1_write", {28'd0, ifc.reg_write}, 32'b1000);
        chk("clr_x1_bus",   {16'd0, bus},           32'h0000);
        @(negedge clk);
        chk("clr_r3",       {16'd0, rf[3]},         32'h0000);
        chk("clr_done",     {31'd0, ifc.done},      32'd1);
    endtask

    task automatic test_swap;
        preload(2'd0, 16'h1234);
        preload(2'd1, 16'hABCD);
        send(SWAP, 2'd1, 2'd0, 16'h0000);
        chk("swap_x1", {12'd0, ifc.reg_read, ifc.reg_write, bus}, {12'd0, 4'b0001, 4'b0000, 16'h1234});
        @(negedge clk);
        chk("swap_x2", {12'd0, ifc.reg_read, ifc.reg_write, bus}, {12'd0, 4'b0010, 4'b0001, 16'hABCD});
        chk("swap_x2_done", {31'd0, ifc.done}, 32'd0);
        @(negedge clk);
        chk("swap_x3", {12'd0, ifc.reg_read, ifc.reg_write, bus}, {12'd0, 4'b0000, 4'b0010, 16'h1234});
        chk("swap_r0_at_n3", {16'd0, rf[0]}, 32'hABCD);
        chk("swap_x3_done", {31'd0, ifc.done}, 32'd0);
        @(negedge clk);
        chk("swap_done",  {31'd0, ifc.done}, 32'd1);
        chk("swap_r0",    {16'd0, rf[0]},    32'hABCD);
        chk("swap_r1",    {16'd0, rf[1]},    32'h1234);
        send(SWAP, 2'd2, 2'd2, 16'h0000);
        repeat (2) @(negedge clk);
        chk("swap_same_x3_done", {31'd0, ifc.done}, 32'd0);
        @(negedge clk);
        chk("swap_same_done", {31'd0, ifc.done}, 32'd1);
        chk("swap_same_r2",   {16'd0, rf[2]},    32'h5A5A);
    endtask

    task automatic test_back_to_back;
        logic [1:0]  ops [3];
        logic [1:0]  dsts [3];
        logic [1:0]  srcs [3];
        logic [15:0] imms [3];
        int acc_cyc [3];
        int idx, cyc, wait_n;
        logic accept;
        ops[0] = MOV;  dsts[0] = 2'd0; srcs[0] = 2'd3; imms[0] = 16'h0000;
        ops[1] = LDI;  dsts[1] = 2'd2; srcs[1] = 2'd0; imms[1] = 16'hC3C3;
        ops[2] = SWAP; dsts[2] = 2'd2; srcs[2] = 2'd0; imms[2] = 16'h0000;
        preload(2'd3, 16'h0F0F);
        idx = 0; cyc = 0;
        for (int k = 0; k < 3; k++) acc_cyc[k] = 0;
        present(ops[0], dsts[0], srcs[0], imms[0]);
        while (idx < 3 && cyc < 40) begin
            accept = ifc.cmd_ready;
            @(posedge clk);
            cyc++;
            if (accept) begin
                acc_cyc[idx] = cyc;
                idx++;
            end
            @(negedge clk);
            if (idx < 3) present(ops[idx], dsts[idx], srcs[idx], imms[idx]);
            else ifc.cmd_valid = 1'b0;
        end
        ifc.cmd_valid = 1'b0;
        chk("b2b_all_accepted", idx, 3);
        chk("b2b_gap_0_1", acc_cyc[1] - acc_cyc[0], 2);
        chk("b2b_gap_1_2", acc_cyc[2] - acc_cyc[1], 2);
        wait_n = 0;
        while (ifc.done !== 1'b1 && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        chk("b2b_swap_done_latency", wait_n, 3);
        chk("b2b_r0", {16'd0, rf[0]}, 32'hC3C3);
        chk("b2b_r2", {16'd0, rf[2]}, 32'h0F0F);
    endtask

    task automatic test_reset_mid_swap;
        preload(2'd0, 16'h1111);
        preload(2'd1, 16'h2222);
        send(SWAP, 2'd1, 2'd0, 16'h0000);
        @(negedge clk);
        chk("rst_swap_in_x2", {28'd0, ifc.reg_write}, 32'b0001);
        // Reset lands right after the X2 edge has committed the src write.
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_swap_busy",  {31'd0, ifc.busy},      32'd0);
        chk("rst_swap_write", {28'd0, ifc.reg_write}, 32'd0);
        chk("rst_swap_done",  {31'd0, ifc.done},      32'd0);
        @(negedge clk);
        chk("rst_swap_r0", {16'd0, rf[0]}, 32'h2222);
        chk("rst_swap_r1", {16'd0, rf[1]}, 32'h2222);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_swap_no_done", {31'd0, ifc.done}, 32'd0);
        chk("rst_swap_ready",   {31'd0, ifc.cmd_ready}, 32'd1);
        send(MOV, 2'd3, 2'd0, 16'h0000);
        chk("post_rst_mov_x1", {24'd0, ifc.reg_read, ifc.reg_write}, {24'd0, 4'b0001, 4'b1000});
        @(negedge clk);
        chk("post_rst_mov_done", {31'd0, ifc.done}, 32'd1);
        chk("post_rst_mov_r3",   {16'd0, rf[3]},    32'h2222);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = '0;
        test_reset();
        test_idle();
        test_mov();
        test_ldi_clr();
        test_swap();
        test_back_to_back();
        test_reset_mid_swap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_move_sequencer.md
# bus_move_sequencer

Micro-sequencer sitting directly upstream of the general-purpose register file (R0..R3) on the shared 16-bit tri-state data bus. It accepts register-transfer commands over a valid/ready handshake and drives the per-register `read`/`write` strobes, and the bus itself when it is the data source, one bus transfer per cycle. It executes MOV, LDI (load immediate), CLR and SWAP, using an internal temp register for SWAP, and guarantees at most one bus driver per cycle.

## Interface
- `NREG`, 4: number of registers strobed; strobe vectors are one-hot, index = register number.
- `W`, 16: bus and immediate width.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command this cycle.
- `cmd_op`  in  2  00 MOV, 01 LDI, 10 SWAP, 11 CLR.
- `cmd_dst`  in  2  destination register index.
- `cmd_src`  in  2  source register index; MOV and SWAP only.
- `cmd_imm`  in  W  immediate; LDI only.
- `reg_read`  out  NREG  one-hot read strobes; selected register drives the bus.
- `reg_write`  out  NREG  one-hot write strobes; selected register captures the bus on the next rising edge.
- `bus`  inout  W  shared data bus; driven by the sequencer only when it is the source, otherwise `'z`.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse after a command's final bus cycle.

## Operation
- States: IDLE, X1, X2, X3.
- IDLE
  - `cmd_ready`=1, no strobes, `bus`='z.
  - On `cmd_valid && cmd_ready`, latch op/dst/src/imm and go to X1.
- MOV
  - X1: `reg_read[src]`=1, `reg_write[dst]`=1, then IDLE.
- LDI
  - X1: sequencer drives `bus`=imm, `reg_write[dst]`=1, then IDLE.
- CLR
  - X1: sequencer drives `bus`=0, `reg_write[dst]`=1, then IDLE.
- SWAP
  - X1: `reg_read[src]`=1, temp <= bus.
  - X2: `reg_read[dst]`=1, `reg_write[src]`=1.
  - X3: sequencer drives `bus`=temp, `reg_write[dst]`=1, then IDLE.
- Strobes and bus drive are decoded from the registered state and latched fields only. They never depend on the `cmd_*` inputs in the same cycle.
- Invariants, every cycle:
  - At most one `reg_read` bit set.
  - `reg_read` never set while the sequencer drives `bus`.
  - At most one `reg_write` bit set.
- `busy`=1 in X1..X3, otherwise 0. `cmd_ready` = !busy.
- `done` is registered. It is 1 in the cycle after the final bus cycle (X1 for MOV/LDI/CLR, X3 for SWAP); 0 otherwise.
- Boundary cases:
  - MOV with src==dst: normal 1-cycle transfer; value unchanged.
  - SWAP with src==dst: full 3 cycles; value unchanged.
  - `cmd_valid` while busy: ignored (ready=0). The command must be held by the producer.
  - `cmd_src` is ignored for LDI/CLR; `cmd_imm` is ignored for MOV/SWAP/CLR.
- Reset (`reset`=0, asynchronous, any state):
  - State returns to IDLE; temp, latched fields and `done` go to 0.
  - All strobes go to 0, `bus`='z, `busy`=0.
  - An in-flight command is dropped with no `done`. A partial SWAP leaves the register file as written so far.
- Reset values: `cmd_ready`=1, `busy`=0, `done`=0, `reg_read`=0, `reg_write`=0, `bus`='z.

## Timing
- Command accepted at edge N (end of accept cycle). X1 occupies cycle N+1.
- MOV/LDI/CLR:
  - Destination updates at edge N+2.
  - `done`=1 and `cmd_ready`=1 in cycle N+2; the next command can be accepted then.
  - Throughput: one command per 2 cycles.
- SWAP:
  - X1..X3 occupy cycles N+1..N+3.
  - src updates at edge N+3; dst updates at edge N+4.
  - `done` in cycle N+4. Throughput: one per 4 cycles.
- Read-to-write path: the register's tri-state output must settle on `bus` within the same cycle the strobes are high (single-cycle transfer).

## Test plan
- Reset and idle:
  - Assert `reset`=0 mid-cycle. All outputs take their reset values asynchronously.
  - With no command, `bus` stays 'z and no strobes for 10 cycles.
- MOV: R2=0x5A5A, R1=0x0000, issue MOV dst=1 src=2.
  - In X1: `reg_read`=0100, `reg_write`=0010.
  - Result: R1=0x5A5A, R2 unchanged; `done` one cycle later.
- LDI and CLR:
  - LDI dst=3 imm=0xBEEF gives R3=0xBEEF; no `reg_read` bit ever set.
  - Then CLR dst=3 gives R3=0x0000.
- SWAP: R0=0x1234, R1=0xABCD, issue SWAP src=0 dst=1.
  - Exact 3-cycle strobe sequence per Operation.
  - Result: R0=0xABCD, R1=0x1234; `done` at N+4. SWAP src=dst=2 leaves R2 unchanged.
- Back-to-back: hold `cmd_valid` with MOV, LDI, SWAP queued.
  - Accepts occur only when `cmd_ready`=1, at cycles N, N+2, N+4.
  - Bus single-driver invariant is checked every cycle.
- Reset mid-SWAP: assert reset in X2.
  - Immediate return to IDLE, no `done`; R0 already holds the src-write result per the partial sequence.
  - The next MOV after release executes normally.
